// File: rtl/matrix_result_streamer.sv
// Captures an N x N result bus on done_in and drains it as a valid/ready stream of LANES elements per beat.
// Latency 1 from done_in to m_valid. Beats hold under backpressure. A done_in arriving mid-stream is dropped and flagged.
module matrix_result_streamer #(
    parameter int N     = 16,
    parameter int DW    = 16,
    parameter int LANES = 1,
    parameter int CSW   = DW + 2 * $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   done_in,
    input  logic [N*N*DW-1:0]      c_flat,
    input  logic                   transpose,
    input  logic                   clr_overrun,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [LANES*DW-1:0]    m_data,
    output logic [$clog2(N)-1:0]   m_row,
    output logic [$clog2(N)-1:0]   m_col,
    output logic                   m_last,
    output logic                   busy,
    output logic                   overrun,
    output logic [CSW-1:0]         checksum,
    output logic                   checksum_valid
);
    localparam int AW    = $clog2(N);
    localparam int PW    = 2 * AW;
    localparam int LG    = $clog2(LANES);
    localparam int BEATS = N * N / LANES;
    localparam int BW    = PW - LG;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t              state_q, state_d;
    logic [N*N*DW-1:0]   shadow_q, shadow_d;
    logic                trans_q, trans_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [CSW-1:0]      sum_q, sum_d;
    logic                csv_q, csv_d;
    logic                ovr_q, ovr_d;
    logic                restart_q, restart_d;

    logic [PW-1:0]       pos;
    logic [AW-1:0]       row, col;
    logic [LANES*DW-1:0] beat_data;
    logic [CSW-1:0]      beat_sum;
    logic [CSW-1:0]      base;
    logic                hs, last, fin, capture;

    // Element position of lane 0; the upper half indexes the major dimension.
    always_comb begin
        pos       = PW'(beat_q) << LG;
        row       = trans_q ? pos[AW-1:0] : pos[PW-1:AW];
        col       = trans_q ? pos[PW-1:AW] : pos[AW-1:0];
        beat_data = '0;
        beat_sum  = '0;
        for (int k = 0; k < LANES; k++) begin
            int          idx;
            logic [DW-1:0] lane;
            idx  = trans_q ? (int'(row) + k) * N + int'(col)
                           : int'(row) * N + int'(col) + k;
            lane = shadow_q[idx*DW +: DW];
            beat_data[k*DW +: DW] = lane;
            beat_sum = beat_sum + {{(CSW-DW){lane[DW-1]}}, lane};
        end
    end

    assign hs   = (state_q == STREAM) && m_ready;
    assign last = (beat_q == BW'(BEATS - 1));
    assign fin  = hs && last;

    always_comb begin
        state_d   = state_q;
        trans_d   = trans_q;
        beat_d    = beat_q;
        csv_d     = 1'b0;
        ovr_d     = ovr_q;
        restart_d = 1'b0;
        capture   = 1'b0;
        // After a back-to-back capture the completed sum is shown for one cycle, then dropped.
        base      = restart_q ? '0 : sum_q;
        sum_d     = base;
        if (clr_overrun) ovr_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (done_in) begin
                    capture = 1'b1;
                    state_d = STREAM;
                    trans_d = transpose;
                    beat_d  = '0;
                    sum_d   = '0;
                end
            end
            STREAM: begin
                if (hs) begin
                    beat_d = beat_q + 1'b1;
                    sum_d  = base + beat_sum;
                end
                if (fin) begin
                    csv_d  = 1'b1;
                    beat_d = '0;
                    if (done_in) begin
                        capture   = 1'b1;
                        trans_d   = transpose;
                        restart_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (done_in) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        shadow_d = capture ? c_flat : shadow_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            trans_q   <= 1'b0;
            beat_q    <= '0;
            sum_q     <= '0;
            csv_q     <= 1'b0;
            ovr_q     <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            trans_q   <= trans_d;
            beat_q    <= beat_d;
            sum_q     <= sum_d;
            csv_q     <= csv_d;
            ovr_q     <= ovr_d;
            restart_q <= restart_d;
        end
    end

    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    assign busy           = (state_q == STREAM);
    assign m_valid        = busy;
    assign m_data         = busy ? beat_data : '0;
    assign m_row          = busy ? row : '0;
    assign m_col          = busy ? col : '0;
    assign m_last         = busy && last;
    assign overrun        = ovr_q;
    assign checksum       = sum_q;
    assign checksum_valid = csv_q;
endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed bench for matrix_result_streamer: a LANES=1 instance for ordering, backpressure,
// overrun, back-to-back capture and reset, and a LANES=4 instance for multi-lane beats.
module tb_matrix_result_streamer;
    localparam int N   = 16;
    localparam int DW  = 16;
    localparam int CSW = 24;
    localparam int NN  = N * N;

    logic              clk = 1'b0;
    logic              rst, done_in, done4, transpose, clr_overrun, m_ready, m_ready4;
    logic [NN*DW-1:0]  c_flat, next_flat;

    logic              m_valid, m_last, busy, overrun, checksum_valid;
    logic [DW-1:0]     m_data;
    logic [3:0]        m_row, m_col;
    logic [CSW-1:0]    checksum;

    logic              m_valid4, m_last4, busy4, overrun4, checksum_valid4;
    logic [4*DW-1:0]   m_data4;
    logic [3:0]        m_row4, m_col4;
    logic [CSW-1:0]    checksum4;

    logic [DW-1:0]     mat [NN];
    int tests = 0;
    int fails = 0;

    matrix_result_streamer #(.N(N), .DW(DW), .LANES(1)) u_dut (
        .clk(clk), .rst(rst), .done_in(done_in), .c_flat(c_flat), .transpose(transpose),
        .clr_overrun(clr_overrun), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_row(m_row), .m_col(m_col), .m_last(m_last), .busy(busy), .overrun(overrun),
        .checksum(checksum), .checksum_valid(checksum_valid)
    );

    matrix_result_streamer #(.N(N), .DW(DW), .LANES(4)) u_dut4 (
        .clk(clk), .rst(rst), .done_in(done4), .c_flat(c_flat), .transpose(transpose),
        .clr_overrun(clr_overrun), .m_valid(m_valid4), .m_ready(m_ready4), .m_data(m_data4),
        .m_row(m_row4), .m_col(m_col4), .m_last(m_last4), .busy(busy4), .overrun(overrun4),
        .checksum(checksum4), .checksum_valid(checksum_valid4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mat(input int kind);
        for (int i = 0; i < NN; i++) begin
            case (kind)
                0:       mat[i] = 16'(i);
                1:       mat[i] = 16'hFFFF;
                default: mat[i] = 16'h8000 ^ 16'(i);
            endcase
        end
    endtask

    function automatic logic [NN*DW-1:0] pack_mat();
        logic [NN*DW-1:0] f;
        for (int i = 0; i < NN; i++) f[i*DW +: DW] = mat[i];
        return f;
    endfunction

    task automatic capture(input logic tr, input logic wide);
        c_flat    = pack_mat();
        transpose = tr;
        if (wide) done4 = 1'b1; else done_in = 1'b1;
        step();
        done_in = 1'b0;
        done4   = 1'b0;
    endtask

    // Drains the LANES=1 instance, checking every presented beat against mat.
    task automatic drain1(input logic tr, input int mode, input int inj_beat,
                          input logic inj_last, input logic [CSW-1:0] exp_cs);
        int   b = 0;
        int   cyc = 0;
        int   stall = 0;
        logic injected = 1'b0;
        int   r, c;
        while (b < NN && cyc < 4000) begin
            if (mode == 1 && b == 10 && stall < 5) begin
                m_ready = 1'b0;
                stall++;
            end else if (mode == 1 && b > 10) begin
                m_ready = 1'($urandom_range(0, 1));
            end else begin
                m_ready = 1'b1;
            end
            if (b == inj_beat && !injected) begin
                done_in  = 1'b1;
                c_flat   = next_flat;
                injected = 1'b1;
            end
            r = tr ? b % N : b / N;
            c = tr ? b / N : b % N;
            chk("valid", m_valid, 1);
            chk("busy", busy, 1);
            chk("data", m_data, mat[r*N + c]);
            chk("row", m_row, r);
            chk("col", m_col, c);
            chk("last", m_last, (b == NN - 1));
            step();
            done_in = 1'b0;
            if (m_ready) b++;
            cyc++;
        end
        if (b < NN) chk("drain_timeout", b, NN);
        chk("cs_valid_pulse", checksum_valid, 1);
        chk("checksum", checksum, exp_cs);
        chk("valid_after_last", m_valid, inj_last);
        if (!inj_last) begin
            step();
            chk("cs_valid_drop", checksum_valid, 0);
            chk("checksum_hold", checksum, exp_cs);
        end
    endtask

    task automatic drain4(input logic [CSW-1:0] exp_cs);
        logic [4*DW-1:0] e;
        int r, c;
        for (int b = 0; b < NN / 4; b++) begin
            r = (b * 4) / N;
            c = (b * 4) % N;
            for (int k = 0; k < 4; k++) e[k*DW +: DW] = mat[r*N + c + k];
            chk("valid4", m_valid4, 1);
            chk("busy4", busy4, 1);
            chk("data4", m_data4, e);
            chk("row4", m_row4, r);
            chk("col4", m_col4, c);
            chk("last4", m_last4, (b == NN / 4 - 1));
            step();
        end
        chk("cs_valid4", checksum_valid4, 1);
        chk("checksum4", checksum4, exp_cs);
        chk("valid4_end", m_valid4, 0);
        chk("overrun4", overrun4, 0);
    endtask

    initial begin
        rst = 1'b1; done_in = 1'b0; done4 = 1'b0; transpose = 1'b0; clr_overrun = 1'b0;
        m_ready = 1'b0; m_ready4 = 1'b1; c_flat = '0; next_flat = '0;
        set_mat(0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        step();
        chk("rst_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_cs_valid", checksum_valid, 0);
        chk("rst_last", m_last, 0);

        // Row-major, column-major, then backpressured row-major.
        capture(1'b0, 1'b0);
        drain1(1'b0, 0, -1, 1'b0, 24'd32640);
        capture(1'b1, 1'b0);
        drain1(1'b1, 0, -1, 1'b0, 24'd32640);
        capture(1'b0, 1'b0);
        drain1(1'b0, 1, -1, 1'b0, 24'd32640);

        // Dropped capture mid-stream, then clear.
        set_mat(2);
        next_flat = pack_mat();
        set_mat(0);
        capture(1'b0, 1'b0);
        drain1(1'b0, 0, 100, 1'b0, 24'd32640);
        chk("overrun_set", overrun, 1);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        chk("overrun_clr", overrun, 0);

        // Capture coincident with final handshake, next matrix all -1.
        set_mat(1);
        next_flat = pack_mat();
        set_mat(0);
        capture(1'b0, 1'b0);
        drain1(1'b0, 0, NN - 1, 1'b1, 24'd32640);
        chk("boundary_no_overrun", overrun, 0);
        set_mat(1);
        drain1(1'b0, 0, -1, 1'b0, 24'hFFFF00);

        // Reset mid-stream.
        set_mat(0);
        capture(1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            m_ready = 1'b1;
            step();
        end
        chk("mid_row", m_row, 6);
        rst = 1'b1;
        #1;
        chk("mrst_valid", m_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_checksum", checksum, 0);
        chk("mrst_cs_valid", checksum_valid, 0);
        chk("mrst_last", m_last, 0);
        chk("mrst_data", m_data, 0);
        step();
        rst = 1'b0;
        step();
        capture(1'b0, 1'b0);
        drain1(1'b0, 0, -1, 1'b0, 24'd32640);

        // Four lanes per beat.
        capture(1'b0, 1'b1);
        drain4(24'd32640);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
